// File: rtl/stream_framefifo_pkg.sv
// Shared types for stream_framefifo: input FSM states and the FIFO entry layout.
// Entry = {TUSER, TLAST, TDATA}; the offsets below are measured upward from bit DW.
package stream_framefifo_pkg;

    typedef enum logic [0:0] {
        ST_RESYNC = 1'b0,
        ST_PASS   = 1'b1
    } fsm_state_t;

    localparam int unsigned ENTRY_LAST_OFS = 0;
    localparam int unsigned ENTRY_USER_OFS = 1;
    localparam int unsigned ENTRY_FLAG_W   = 2;

endpackage

// File: rtl/vid_fifo_mem.sv
// Simple dual-port storage for stream_framefifo: one write port, one registered read port.
// The storage array and the read register carry no reset.
module vid_fifo_mem #(
    parameter int AW = 10,
    parameter int WW = 26
) (
    input  logic          i_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [WW-1:0] rd_data
);

    logic [WW-1:0] mem_r [0:(1<<AW)-1];

    // Write port and registered read (old data on same-address collision).
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/stream_framefifo.sv
// Frame-aware elastic buffer: non-stallable AXI video stream in, handshaked stream out.
// Optional statistics (o_dropped_frames, o_max_fill) are built when STREAM_FRAMEFIFO_STATS_EN is defined.
module stream_framefifo
    import stream_framefifo_pkg::*;
#(
    parameter int LGFIFO           = 10,
    parameter int DW               = 24,
    parameter int OPT_TUSER_IS_SOF = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              S_AXIS_TVALID,
    input  logic [DW-1:0]     S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    input  logic              S_AXIS_TUSER,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DW-1:0]     M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TUSER,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_overflow,
    output logic [15:0]       o_dropped_frames,
    output logic [LGFIFO:0]   o_max_fill
);

    localparam int EW = DW + int'(ENTRY_FLAG_W);
    localparam logic [LGFIFO:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};

    fsm_state_t          state_r;
    fsm_state_t          state_next_s;
    logic [LGFIFO:0]     fill_r;
    logic [LGFIFO:0]     fill_next_s;
    logic [LGFIFO-1:0]   wr_ptr_r;
    logic [LGFIFO-1:0]   rd_ptr_r;
    logic [LGFIFO-1:0]   rd_ptr_next_s;
    logic                full_s;
    logic                wr_s;
    logic                rd_s;
    logic                ovf_s;
    logic                ovf_r;
    logic                tvalid_r;
    logic                byp_sel_r;
    logic [EW-1:0]       byp_data_r;
    logic [EW-1:0]       wr_entry_s;
    logic [EW-1:0]       mem_q_s;
    logic [EW-1:0]       head_s;

    // Full is judged on the registered fill; a same-cycle read does not free a slot.
    always_comb begin
        full_s        = (fill_r == DEPTH);
        rd_s          = (fill_r != {(LGFIFO+1){1'b0}}) && M_AXIS_TREADY;
        wr_entry_s    = {S_AXIS_TUSER, S_AXIS_TLAST, S_AXIS_TDATA};
        fill_next_s   = fill_r + {{LGFIFO{1'b0}}, wr_s} - {{LGFIFO{1'b0}}, rd_s};
        rd_ptr_next_s = rd_ptr_r + {{(LGFIFO-1){1'b0}}, rd_s};
    end

    // Input FSM: hunt for a frame boundary in RESYNC, store every beat in PASS.
    always_comb begin
        state_next_s = state_r;
        wr_s         = 1'b0;
        ovf_s        = 1'b0;
        case (state_r)
            ST_RESYNC: begin
                if (!S_AXIS_TVALID) begin
                    state_next_s = ST_RESYNC;
                end else if (OPT_TUSER_IS_SOF != 0) begin
                    if (!S_AXIS_TUSER) begin
                        state_next_s = ST_RESYNC;
                    end else if (full_s) begin
                        ovf_s = 1'b1;
                    end else begin
                        wr_s         = 1'b1;
                        state_next_s = ST_PASS;
                    end
                end else begin
                    if (S_AXIS_TLAST) begin
                        state_next_s = ST_PASS;
                    end else begin
                        state_next_s = ST_RESYNC;
                    end
                end
            end
            ST_PASS: begin
                if (!S_AXIS_TVALID) begin
                    state_next_s = ST_PASS;
                end else if (full_s) begin
                    ovf_s        = 1'b1;
                    state_next_s = ST_RESYNC;
                end else begin
                    wr_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_RESYNC;
            end
        endcase
    end

    // Pointers, fill, FSM state and the write-to-head bypass register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r    <= ST_RESYNC;
            fill_r     <= {(LGFIFO+1){1'b0}};
            wr_ptr_r   <= {LGFIFO{1'b0}};
            rd_ptr_r   <= {LGFIFO{1'b0}};
            ovf_r      <= 1'b0;
            tvalid_r   <= 1'b0;
            byp_sel_r  <= 1'b0;
            byp_data_r <= {EW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            fill_r    <= fill_next_s;
            wr_ptr_r  <= wr_ptr_r + {{(LGFIFO-1){1'b0}}, wr_s};
            rd_ptr_r  <= rd_ptr_next_s;
            ovf_r     <= ovf_s;
            tvalid_r  <= (fill_next_s != {(LGFIFO+1){1'b0}});
            // The RAM returns stale data when the new head is written this same edge.
            byp_sel_r <= wr_s && (wr_ptr_r == rd_ptr_next_s);
            if (wr_s) begin
                byp_data_r <= wr_entry_s;
            end
        end
    end

    vid_fifo_mem #(
        .AW (LGFIFO),
        .WW (EW)
    ) u_mem (
        .i_clk   (i_clk),
        .wr_en   (wr_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_entry_s),
        .rd_addr (rd_ptr_next_s),
        .rd_data (mem_q_s)
    );

    assign head_s        = byp_sel_r ? byp_data_r : mem_q_s;
    assign M_AXIS_TVALID = tvalid_r;
    assign M_AXIS_TDATA  = tvalid_r ? head_s[DW-1:0] : {DW{1'b0}};
    assign M_AXIS_TLAST  = tvalid_r & head_s[DW + int'(ENTRY_LAST_OFS)];
    assign M_AXIS_TUSER  = tvalid_r & head_s[DW + int'(ENTRY_USER_OFS)];
    assign o_fill        = fill_r;
    assign o_overflow    = ovf_r;

`ifdef STREAM_FRAMEFIFO_STATS_EN
    logic [15:0]     dropped_r;
    logic [LGFIFO:0] max_fill_r;

    // Frame-abort counter (saturating) and fill high-water mark.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            dropped_r  <= 16'd0;
            max_fill_r <= {(LGFIFO+1){1'b0}};
        end else begin
            if (ovf_s && (state_r == ST_PASS) && (dropped_r != 16'hFFFF)) begin
                dropped_r <= dropped_r + 16'd1;
            end
            if (fill_next_s > max_fill_r) begin
                max_fill_r <= fill_next_s;
            end
        end
    end

    assign o_dropped_frames = dropped_r;
    assign o_max_fill       = max_fill_r;
`else
    assign o_dropped_frames = 16'd0;
    assign o_max_fill       = {(LGFIFO+1){1'b0}};
`endif

endmodule

// File: tb/tb_stream_framefifo.sv
// Scoreboard bench for stream_framefifo: dut0 (TLAST = end of frame), dut1 (TUSER = start of frame).
module tb_stream_framefifo;

    localparam int LG = 4;
    localparam int DW = 24;

    typedef struct packed {
        logic          u;
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          s0_valid, s0_last, s0_user, m0_ready;
    logic [DW-1:0] s0_data;
    logic          m0_valid, m0_last, m0_user, ovf0;
    logic [DW-1:0] m0_data;
    logic [LG:0]   fill0, max0;
    logic [15:0]   drop0;

    logic          s1_valid, s1_last, s1_user, m1_ready;
    logic [DW-1:0] s1_data;
    logic          m1_valid, m1_last, m1_user, ovf1;
    logic [DW-1:0] m1_data;
    logic [LG:0]   fill1, max1;
    logic [15:0]   drop1;

    stream_framefifo #(.LGFIFO(LG), .DW(DW), .OPT_TUSER_IS_SOF(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .S_AXIS_TVALID(s0_valid), .S_AXIS_TDATA(s0_data), .S_AXIS_TLAST(s0_last), .S_AXIS_TUSER(s0_user),
        .M_AXIS_TVALID(m0_valid), .M_AXIS_TREADY(m0_ready), .M_AXIS_TDATA(m0_data),
        .M_AXIS_TLAST(m0_last), .M_AXIS_TUSER(m0_user),
        .o_fill(fill0), .o_overflow(ovf0), .o_dropped_frames(drop0), .o_max_fill(max0)
    );

    stream_framefifo #(.LGFIFO(LG), .DW(DW), .OPT_TUSER_IS_SOF(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n),
        .S_AXIS_TVALID(s1_valid), .S_AXIS_TDATA(s1_data), .S_AXIS_TLAST(s1_last), .S_AXIS_TUSER(s1_user),
        .M_AXIS_TVALID(m1_valid), .M_AXIS_TREADY(m1_ready), .M_AXIS_TDATA(m1_data),
        .M_AXIS_TLAST(m1_last), .M_AXIS_TUSER(m1_user),
        .o_fill(fill1), .o_overflow(ovf1), .o_dropped_frames(drop1), .o_max_fill(max1)
    );

    beat_t q0[$];
    beat_t q1[$];
    int n_checks = 0;
    int n_fail   = 0;
    int ovf_cnt0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor dut0: pop/compare on handshake, hold check while stalled, overflow pulse count.
    beat_t prev0;
    logic  stall0 = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {m0_user, m0_last, m0_data};
        if (stall0 && m0_valid) chk("hold0", 32'(cur), 32'(prev0));
        if (m0_valid && m0_ready) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out0_extra: got %0h, expected no beat", cur);
            end else begin
                e = q0.pop_front();
                chk("out0", 32'(cur), 32'(e));
            end
        end
        stall0 = m0_valid && !m0_ready;
        prev0  = cur;
        if (ovf0) ovf_cnt0++;
    end

    // Monitor dut1.
    beat_t prev1;
    logic  stall1 = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {m1_user, m1_last, m1_data};
        if (stall1 && m1_valid) chk("hold1", 32'(cur), 32'(prev1));
        if (m1_valid && m1_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out1_extra: got %0h, expected no beat", cur);
            end else begin
                e = q1.pop_front();
                chk("out1", 32'(cur), 32'(e));
            end
        end
        stall1 = m1_valid && !m1_ready;
        prev1  = cur;
    end

    task automatic send0(input logic [DW-1:0] d, input logic l, input logic u, input logic exp);
        s0_valid = 1'b1; s0_data = d; s0_last = l; s0_user = u;
        if (exp) q0.push_back({u, l, d});
        @(posedge clk); #1;
        s0_valid = 1'b0; s0_last = 1'b0; s0_user = 1'b0;
    endtask

    task automatic send1(input logic [DW-1:0] d, input logic l, input logic u, input logic exp);
        s1_valid = 1'b1; s1_data = d; s1_last = l; s1_user = u;
        if (exp) q1.push_back({u, l, d});
        @(posedge clk); #1;
        s1_valid = 1'b0; s1_last = 1'b0; s1_user = 1'b0;
    endtask

    task automatic drain0();
        int n = 0;
        m0_ready = 1'b1;
        while ((q0.size() != 0 || m0_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain0_queue", 32'(q0.size()), 32'd0);
        chk("drain0_fill", 32'(fill0), 32'd0);
    endtask

    task automatic drain1();
        int n = 0;
        m1_ready = 1'b1;
        while ((q1.size() != 0 || m1_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain1_queue", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        int ovf_base;
        int k;
        rst_n = 1'b0;
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0; s0_user = 1'b0; m0_ready = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; s1_user = 1'b0; m1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m0_valid), 32'd0);
        chk("rst_beat", 32'({m0_user, m0_last, m0_data}), 32'd0);
        chk("rst_fill", 32'(fill0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_drop", 32'(drop0), 32'd0);
        chk("rst_max", 32'(max0), 32'd0);
        chk("rst_valid1", 32'(m1_valid), 32'd0);
        rst_n = 1'b1;

        // dut1: SOF beat right after reset is accepted and shows one cycle after its write.
        m1_ready = 1'b1;
        send1(24'h100000, 1'b0, 1'b1, 1'b1);
        chk("sof_latency_valid", 32'(m1_valid), 32'd1);
        chk("sof_latency_user", 32'(m1_user), 32'd1);
        chk("sof_latency_data", 32'(m1_data), 32'h100000);
        for (int i = 1; i < 6; i++) send1(24'h100000 + 24'(i), (i % 3) == 2, 1'b0, 1'b1);
        drain1();

        // dut0: first frame discarded while resyncing, second buffered with no reader.
        for (int i = 0; i < 12; i++) send0(24'hA00000 + 24'(i), i == 11, (i % 4) == 3, 1'b0);
        chk("resync_fill", 32'(fill0), 32'd0);
        m0_ready = 1'b0;
        for (int i = 0; i < 12; i++) send0(24'hB00000 + 24'(i), i == 11, (i % 4) == 3, 1'b1);
        chk("peak_fill12", 32'(fill0), 32'd12);
        drain0();

        // 20-beat frame into a 16-deep FIFO with no reader.
        m0_ready = 1'b0;
        ovf_base = ovf_cnt0;
        for (int i = 0; i < 20; i++) send0(24'hC00000 + 24'(i), i == 19, (i % 4) == 3, i < 16);
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_pulses", 32'(ovf_cnt0 - ovf_base), 32'd1);
        chk("full_fill16", 32'(fill0), 32'd16);
`ifdef STREAM_FRAMEFIFO_STATS_EN
        chk("dropped_1", 32'(drop0), 32'd1);
`else
        chk("dropped_off", 32'(drop0), 32'd0);
`endif
        drain0();
        for (int i = 0; i < 4; i++) send0(24'hD00000 + 24'(i), i == 3, 1'b0, 1'b1);
        drain0();

        // Full FIFO: a write that coincides with a read is still rejected.
        m0_ready = 1'b0;
        for (int i = 0; i < 16; i++) send0(24'hE00000 + 24'(i), 1'b0, 1'b0, 1'b1);
        chk("full_again", 32'(fill0), 32'd16);
        m0_ready = 1'b1;
        send0(24'hE00010, 1'b0, 1'b0, 1'b0);
        m0_ready = 1'b0;
        chk("rw_full_ovf", 32'(ovf0), 32'd1);
        chk("rw_full_fill15", 32'(fill0), 32'd15);
        for (int i = 17; i < 20; i++) send0(24'hE00000 + 24'(i), i == 19, 1'b0, 1'b0);
        chk("resync_no_ovf", 32'(ovf0), 32'd0);
        drain0();
`ifdef STREAM_FRAMEFIFO_STATS_EN
        chk("dropped_2", 32'(drop0), 32'd2);
        chk("max_fill16", 32'(max0), 32'd16);
`else
        chk("max_fill_off", 32'(max0), 32'd0);
`endif

        // Random backpressure over three 8-beat frames with sparse input.
        k = 0;
        while (k < 24) begin
            m0_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                s0_valid = 1'b1; s0_data = 24'hF00000 + 24'(k);
                s0_last = (k % 8) == 7; s0_user = (k % 4) == 3;
                q0.push_back({s0_user, s0_last, s0_data});
                k++;
            end else begin
                s0_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        s0_valid = 1'b0; s0_last = 1'b0; s0_user = 1'b0;
        drain0();
        chk("max_le_depth", 32'(max0 <= 5'd16), 32'd1);

        // Reset mid-frame with 7 beats held.
        m0_ready = 1'b0;
        for (int i = 0; i < 7; i++) send0(24'h700000 + 24'(i), 1'b0, 1'b0, 1'b1);
        chk("pre_reset_fill7", 32'(fill0), 32'd7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_fill0", 32'(fill0), 32'd0);
        chk("reset_valid0", 32'(m0_valid), 32'd0);
        q0.delete();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_valid", 32'(m0_valid), 32'd0);
        chk("post_reset_drop", 32'(drop0), 32'd0);

        // dut1 after reset: TUSER=0 beats discarded until a SOF arrives.
        m1_ready = 1'b1;
        send1(24'h200000, 1'b0, 1'b0, 1'b0);
        send1(24'h200001, 1'b1, 1'b0, 1'b0);
        chk("sof_resync_empty", 32'(fill1), 32'd0);
        for (int i = 0; i < 4; i++) send1(24'h300000 + 24'(i), i == 3, i == 0, 1'b1);
        drain1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_framefifo.md
# stream_framefifo

Frame-aware elastic buffer sitting directly downstream of the sync-to-stream converter, whose AXI video stream output cannot tolerate backpressure. Absorbs consumer stalls in a synchronous FIFO and presents a fully handshaked AXI video stream to the next stage (framebuffer writer, scaler). On overflow it discards the rest of the damaged frame, then re-aligns to a frame boundary so downstream only ever receives frames that start cleanly.

## Interface
- LGFIFO, 10: log2 of FIFO depth in beats (depth D = 2^LGFIFO).
- DW, 24: pixel data width.
- OPT_TUSER_IS_SOF, 0: 0 = TLAST marks end of frame and TUSER marks end of line; 1 = TUSER marks start of frame and TLAST marks end of line. Applies to both input and output streams.

- i_clk  in  1  Single clock; all logic runs on its rising edge.
- i_reset_n  in  1  Reset, synchronous and active-low.
- S_AXIS_TVALID  in  1  Input beat valid. There is no TREADY; the source never stalls.
- S_AXIS_TDATA  in  DW  Input pixel.
- S_AXIS_TLAST  in  1  Input last-beat flag, meaning set by OPT_TUSER_IS_SOF.
- S_AXIS_TUSER  in  1  Input user flag, meaning set by OPT_TUSER_IS_SOF.
- M_AXIS_TVALID  out  1  Output beat valid.
- M_AXIS_TREADY  in  1  Downstream ready.
- M_AXIS_TDATA  out  DW  Output pixel.
- M_AXIS_TLAST  out  1  Passed through unchanged with the beat.
- M_AXIS_TUSER  out  1  Passed through unchanged with the beat.
- o_fill  out  LGFIFO+1  Current FIFO occupancy.
- o_overflow  out  1  One-cycle pulse when an input beat is lost because the FIFO is full.
- o_dropped_frames  out  16  Count of frames aborted; saturates at 16'hFFFF.
- o_max_fill  out  LGFIFO+1  High-water mark of o_fill.

## Operation
- The input FSM has two states, RESYNC and PASS. Reset enters RESYNC.
- RESYNC, OPT_TUSER_IS_SOF=0: every beat is discarded. A beat with TLAST=1 (also discarded) moves the FSM to PASS, so the next beat is the first beat of a frame.
- RESYNC, OPT_TUSER_IS_SOF=1: beats with TUSER=0 are discarded. A beat with TUSER=1 is written to the FIFO and the FSM moves to PASS.
- PASS: every valid beat is written as {TUSER, TLAST, TDATA}.
- Full rule: the write is permitted only if the registered fill < D. A simultaneous read does not rescue a write to a full FIFO.
- Overflow (PASS, beat valid, fill == D):
  - the beat is dropped;
  - o_overflow pulses;
  - o_dropped_frames increments;
  - the FSM moves to RESYNC.
- Beats already in the FIFO still drain. Downstream therefore sees a truncated frame with no end marker, followed by a clean frame.
- Overflow in RESYNC cannot occur, because nothing is written there except the SOF beat. If that SOF beat meets a full FIFO: it is dropped, o_overflow pulses, no count is added, and the FSM stays in RESYNC.
- Output side: M_AXIS_TVALID = (fill != 0). A read occurs on TVALID && TREADY.
- Fill arithmetic: fill + write − read, computed in LGFIFO+1 bits. Pointers are LGFIFO bits and wrap naturally.

## Timing
- Reset values: M_AXIS_TVALID=0, TDATA/TLAST/TUSER=0, o_fill=0, o_overflow=0, o_dropped_frames=0, o_max_fill=0. FSM=RESYNC, pointers=0.
- Latency: a beat written in cycle N is presented on M_AXIS at cycle N+1 at the earliest (registered read, first-word fall-through).
- Output data is held stable while TVALID && !TREADY.
- With continuous TREADY and no overflow, throughput is one beat per cycle.
- o_fill and o_max_fill are registered and reflect the writes and reads of the previous cycle.
- Reset asserted mid-frame:
  - the FIFO contents are discarded (fill=0);
  - M_AXIS_TVALID drops in the following cycle;
  - the output is not drained.

## Configuration
- STREAM_FRAMEFIFO_STATS_EN defined: o_dropped_frames and o_max_fill are live as described above.
- Not defined: both ports remain present but are driven constant 0, and their counters are not synthesised. o_overflow and o_fill are always present.

## Structure
- Package stream_framefifo_pkg holds:
  - the FSM state enum (RESYNC, PASS);
  - the entry-packing localparams (bit positions of TUSER and TLAST above DW).
- One sub-module, vid_fifo_mem: a simple dual-port RAM of D × (DW+2), with one write port, one registered read port and no reset on the storage.
- This module owns the pointers, fill logic and FSM.

## Test plan
- Reset, then OPT=0: a 4×3 frame with TLAST on its last beat, then a second frame. The first frame is discarded; the second appears intact; o_fill peaks at 12 with TREADY=0.
- OPT=1, TUSER on first beat: the first frame is accepted immediately. The first M_AXIS beat appears one cycle after the write and carries TUSER=1.
- LGFIFO=4, TREADY held 0, 20-beat frame: beats 17–20 dropped, o_overflow pulses once then stays 0 in RESYNC, o_dropped_frames=1. After TREADY=1, exactly 16 beats drain and the next full frame passes intact.
- Fill == D, and a write coincides with a read: the write is rejected, o_overflow=1, o_fill=15 in the next cycle.
- Random TREADY (50%) over 3 frames: output beat sequence equals the input, TDATA is stable while stalled, and o_max_fill ≤ D.
- i_reset_n=0 mid-frame with fill=7: the next cycle shows o_fill=0 and M_AXIS_TVALID=0. Without STREAM_FRAMEFIFO_STATS_EN, o_dropped_frames reads 0 after an overflow.
